// File: rtl/cl_axi_mem_rsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cl_axi_mem_rsp_pkg
// Description : Shared types, response codes and the address check for the
//               on-chip AXI4 memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package cl_axi_mem_rsp_pkg;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] BEAT_SIZE   = 3'b110;

    // A burst is in error when it starts outside the RAM window (idx_w index
    // bits above the 64B beat offset) or does not use full 64B beats.
    function automatic logic burst_err(input logic [63:0] addr,
                                       input logic [2:0]  size,
                                       input int          idx_w);
        return ((addr >> (idx_w + 6)) != 64'd0) || (size != BEAT_SIZE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cl_axi_mem_rsp_ram.sv
`default_nettype none
// ============================================================================
// Module      : cl_axi_mem_rsp_ram
// Description : DEPTH x DATA_WIDTH RAM with one byte-enabled write port and
//               one synchronous read-first read port.
// Revision    : 1.0 - initial release
// ============================================================================
module cl_axi_mem_rsp_ram
    import cl_axi_mem_rsp_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_i,
    input  logic [ADDR_W-1:0]       waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    re_i,
    input  logic [ADDR_W-1:0]       raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int STRB_W = DATA_WIDTH / 8;

    // Array is deliberately not reset so contents survive rst_n.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-lane write; only lanes with a set strobe are updated.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Registered read; a same-edge write to the same row returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/cl_axi_mem_rsp.sv
`default_nettype none
// ============================================================================
// Module      : cl_axi_mem_rsp
// Description : AXI4 subordinate backing a 512b master bus with on-chip RAM.
//               Independent write/read channels, one burst per direction,
//               INCR bursts of 64B beats, SLVERR for bad address or size.
// Revision    : 1.0 - initial release
// ============================================================================
module cl_axi_mem_rsp
    import cl_axi_mem_rsp_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 9,
    parameter int DEPTH      = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // write address
    input  logic [ID_WIDTH-1:0]     awid_i,
    input  logic [63:0]             awaddr_i,
    input  logic [7:0]              awlen_i,
    input  logic [2:0]              awsize_i,
    input  logic [10:0]             awuser_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    // write data
    input  logic [ID_WIDTH-1:0]     wid_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wlast_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    // write response
    output logic [ID_WIDTH-1:0]     bid_o,
    output logic [1:0]              bresp_o,
    output logic [17:0]             buser_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    // read address
    input  logic [ID_WIDTH-1:0]     arid_i,
    input  logic [63:0]             araddr_i,
    input  logic [7:0]              arlen_i,
    input  logic [2:0]              arsize_i,
    input  logic [10:0]             aruser_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    // read data
    output logic [ID_WIDTH-1:0]     rid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o,
    output logic [17:0]             ruser_o,
    output logic                    rvalid_o,
    input  logic                    rready_i
);

    localparam int IDX_W = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    wr_state_t            wr_state_q, wr_state_d;
    logic [ID_WIDTH-1:0]  bid_q;
    logic [1:0]           bresp_q;
    logic [IDX_W-1:0]     widx_q;
    logic [7:0]           wlen_q;
    logic [7:0]           wbeat_q;
    logic                 werr_q;
    logic                 wpast_q;     // all awlen+1 beats seen, no wlast yet

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    rd_state_t            rd_state_q, rd_state_d;
    logic [ID_WIDTH-1:0]  rid_q;
    logic [IDX_W-1:0]     ridx_q;      // index of the beat after the one shown
    logic [7:0]           rlen_q;
    logic [7:0]           rbeat_q;
    logic                 rerr_q;

    logic                    w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
    logic                    w_ram_we, w_ram_re;
    logic [IDX_W-1:0]        w_ram_raddr;
    logic [DATA_WIDTH-1:0]   w_ram_rdata;
    logic                    w_unused;

    assign w_aw_hs = awvalid_i && awready_o;
    assign w_w_hs  = wvalid_i  && wready_o;
    assign w_ar_hs = arvalid_i && arready_o;
    assign w_r_hs  = rvalid_o  && rready_i;

    // Sideband fields carried by the bus but meaningless to a RAM target.
    assign w_unused = ^{wid_i, awuser_i, aruser_i};

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
        end
    end

    // Write FSM next state and handshake outputs.
    always_comb begin
        wr_state_d = wr_state_q;
        awready_o  = 1'b0;
        wready_o   = 1'b0;
        bvalid_o   = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                awready_o = 1'b1;
                if (awvalid_i) wr_state_d = WR_DATA;
            end
            WR_DATA: begin
                wready_o = 1'b1;
                if (wvalid_i && wlast_i) wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Write burst bookkeeping: capture AW, step index/beat, grade response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bid_q   <= '0;
            bresp_q <= RESP_OKAY;
            widx_q  <= '0;
            wlen_q  <= '0;
            wbeat_q <= '0;
            werr_q  <= 1'b0;
            wpast_q <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                bid_q   <= awid_i;
                widx_q  <= awaddr_i[6 +: IDX_W];
                wlen_q  <= awlen_i;
                wbeat_q <= '0;
                werr_q  <= burst_err(awaddr_i, awsize_i, IDX_W);
                wpast_q <= 1'b0;
            end
            if (w_w_hs) begin
                widx_q <= widx_q + IDX_W'(1);
                if (!wpast_q) begin
                    if (wbeat_q == wlen_q) wpast_q <= 1'b1;
                    else                   wbeat_q <= wbeat_q + 8'd1;
                end
                if (wlast_i) begin
                    bresp_q <= (werr_q || wpast_q || (wbeat_q != wlen_q))
                               ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Beats past awlen+1 and bursts in error never reach the RAM.
    assign w_ram_we = w_w_hs && !werr_q && !wpast_q;

    assign bid_o   = bid_q;
    assign bresp_o = bresp_q;
    assign buser_o = '0;

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        rd_state_d = rd_state_q;
        arready_o  = 1'b0;
        rvalid_o   = 1'b0;
        rlast_o    = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                arready_o = 1'b1;
                if (arvalid_i) rd_state_d = RD_DATA;
            end
            RD_DATA: begin
                rvalid_o = 1'b1;
                rlast_o  = (rbeat_q == rlen_q);
                if (rready_i && rlast_o) rd_state_d = RD_IDLE;
            end
        endcase
    end

    // Read burst bookkeeping: capture AR, advance on each non-last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rid_q   <= '0;
            ridx_q  <= '0;
            rlen_q  <= '0;
            rbeat_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                rid_q   <= arid_i;
                ridx_q  <= araddr_i[6 +: IDX_W] + IDX_W'(1);
                rlen_q  <= arlen_i;
                rbeat_q <= '0;
                rerr_q  <= burst_err(araddr_i, arsize_i, IDX_W);
            end
            if (w_r_hs && !rlast_o) begin
                ridx_q  <= ridx_q + IDX_W'(1);
                rbeat_q <= rbeat_q + 8'd1;
            end
        end
    end

    // Prefetch the first beat on AR and the next beat on each accepted beat,
    // so the RAM output register holds whatever beat is currently shown.
    assign w_ram_re    = w_ar_hs || (w_r_hs && !rlast_o);
    assign w_ram_raddr = w_ar_hs ? araddr_i[6 +: IDX_W] : ridx_q;

    assign rid_o   = rid_q;
    assign rdata_o = rerr_q ? '0 : w_ram_rdata;
    assign rresp_o = rerr_q ? RESP_SLVERR : RESP_OKAY;
    assign ruser_o = '0;

    cl_axi_mem_rsp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (w_ram_we),
        .waddr_i (widx_q),
        .wdata_i (wdata_i),
        .wstrb_i (wstrb_i),
        .re_i    (w_ram_re),
        .raddr_i (w_ram_raddr),
        .rdata_o (w_ram_rdata)
    );

endmodule
`default_nettype wire
